// File: rtl/pipe_mem_stage.sv
// Pipeline memory stage: issues aligned load/store requests and returns results
// to writeback through a one-entry output holding register.
module pipe_mem_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [1:0]            in_len,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic                  in_wb_e,
    input  logic [4:0]            in_wb_idx,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_wb_e,
    output logic [4:0]            out_wb_idx,
    output logic                  out_exc,
    output logic [4:0]            fwd_idx,
    output logic [DATA_W-1:0]     fwd_val
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic                sext_q, sext_d;
    logic [1:0]          len_q, len_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic                wb_e_q, wb_e_d;
    logic [4:0]          wb_idx_q, wb_idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_wb_e_q, out_wb_e_d;
    logic [4:0]          out_wb_idx_q, out_wb_idx_d;
    logic                out_exc_q, out_exc_d;

    logic                accept;
    logic                is_access;
    logic                misaligned;
    logic [3:0]          in_size;

    // Extract the addressed bytes from a right-shifted read word and extend.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                      input logic [1:0] len,
                                                      input logic sext);
        int   nbits;
        logic sign;
        nbits = 8 << len;
        if (nbits > int'(DATA_W)) nbits = int'(DATA_W);
        sign = sext & raw[nbits-1];
        for (int b = 0; b < int'(DATA_W); b++) begin
            load_extend[b] = (b < nbits) ? raw[b] : sign;
        end
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] w,
                                                    input logic [1:0] len);
        int sz;
        sz = 1 << len;
        for (int i = 0; i < int'(NB); i++) begin
            replicate[8*i +: 8] = w[8*(i % sz) +: 8];
        end
    endfunction

    function automatic logic [NB-1:0] byte_en(input logic [1:0] len,
                                              input logic [OFF_W-1:0] off);
        logic [NB-1:0] m;
        m = NB'((32'd1 << (32'd1 << len)) - 32'd1);
        return m << off;
    endfunction

    assign in_ready   = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign is_access  = (in_op != 2'b00);
    assign in_size    = 4'(4'd1 << in_len);
    assign misaligned = ((in_addr[2:0] & 3'(in_size - 4'd1)) != 3'd0) ||
                        ((in_len == 2'd3) && (DATA_W == 32));

    // Next-state and output-register load logic.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        sext_d       = sext_q;
        len_d        = len_q;
        off_d        = off_q;
        wb_e_d       = wb_e_q;
        wb_idx_d     = wb_idx_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        out_wb_e_d   = out_wb_e_q;
        out_wb_idx_d = out_wb_idx_q;
        out_exc_d    = out_exc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_access || misaligned) begin
                        out_valid_d  = 1'b1;
                        out_data_d   = DATA_W'(in_addr);
                        out_wb_e_d   = is_access ? 1'b0 : in_wb_e;
                        out_wb_idx_d = in_wb_idx;
                        out_exc_d    = is_access;
                    end else begin
                        state_d  = ST_REQ;
                        we_d     = (in_op == 2'b01);
                        sext_d   = (in_op == 2'b10);
                        len_d    = in_len;
                        off_d    = in_addr[OFF_W-1:0];
                        wb_e_d   = in_wb_e;
                        wb_idx_d = in_wb_idx;
                        addr_d   = {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        be_d     = byte_en(in_len, in_addr[OFF_W-1:0]);
                        wdata_d  = replicate(in_wdata, in_len);
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d      = ST_IDLE;
                    out_valid_d  = 1'b1;
                    out_data_d   = we_q ? '0 :
                                   load_extend(mem_rdata >> {off_q, 3'b000}, len_q, sext_q);
                    out_wb_e_d   = we_q ? 1'b0 : wb_e_q;
                    out_wb_idx_d = wb_idx_q;
                    out_exc_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            sext_q       <= 1'b0;
            len_q        <= 2'd0;
            off_q        <= '0;
            wb_e_q       <= 1'b0;
            wb_idx_q     <= 5'd0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_wb_e_q   <= 1'b0;
            out_wb_idx_q <= 5'd0;
            out_exc_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            sext_q       <= sext_d;
            len_q        <= len_d;
            off_q        <= off_d;
            wb_e_q       <= wb_e_d;
            wb_idx_q     <= wb_idx_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_wb_e_q   <= out_wb_e_d;
            out_wb_idx_q <= out_wb_idx_d;
            out_exc_q    <= out_exc_d;
        end
    end

    assign mem_req    = (state_q == ST_REQ);
    assign mem_we     = mem_req && we_q;
    assign mem_addr   = addr_q;
    assign mem_be     = mem_req ? be_q : '0;
    assign mem_wdata  = wdata_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_wb_e   = out_wb_e_q;
    assign out_wb_idx = out_wb_idx_q;
    assign out_exc    = out_exc_q;
    assign fwd_idx    = (out_valid_q && out_wb_e_q && !out_exc_q) ? out_wb_idx_q : 5'd0;
    assign fwd_val    = out_data_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_pipe_mem_stage;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned NB     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [1:0]        in_len;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic              in_wb_e;
    logic [4:0]        in_wb_idx;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_wb_e;
    logic [4:0]        out_wb_idx;
    logic              out_exc;
    logic [4:0]        fwd_idx;
    logic [DATA_W-1:0] fwd_val;

    int n_checks = 0;
    int n_errors = 0;

    pipe_mem_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_len(in_len),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_wb_e(in_wb_e), .in_wb_idx(in_wb_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_wb_e(out_wb_e), .out_wb_idx(out_wb_idx),
        .out_exc(out_exc), .fwd_idx(fwd_idx), .fwd_val(fwd_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on access size and byte offset.
    function automatic logic [63:0] m_be(input logic [1:0] len, input logic [31:0] addr);
        int sz = 1 << len;
        return ((64'd1 << sz) - 64'd1) << (addr % 8);
    endfunction

    function automatic logic [63:0] m_mask(input logic [1:0] len);
        int sz = 1 << len;
        return (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    endfunction

    function automatic logic [63:0] m_wdata(input logic [1:0] len, input logic [63:0] w);
        int sz = 1 << len;
        logic [63:0] low = w & m_mask(len);
        logic [63:0] rep = 64'd0;
        for (int k = 0; k < 8 / sz; k++) rep = rep | (low << (8 * sz * k));
        return rep;
    endfunction

    function automatic logic [63:0] m_load(input logic [1:0] len, input logic [31:0] addr,
                                           input logic [63:0] rd, input bit sgn);
        int sz = 1 << len;
        logic [63:0] v = (rd >> (8 * (addr % 8))) & m_mask(len);
        if (sgn && v[8*sz-1]) v = v | ~m_mask(len);
        return v;
    endfunction

    // One complete operation: accept, optional memory handshake, output, drain.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] len,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          input logic wbe, input logic [4:0] idx, input logic [63:0] rdata,
                          input int gd, input int rd, input int hd);
        int          sz     = 1 << len;
        bit          access = (op != 2'b00);
        bit          misal  = (addr % sz) != 0;
        bit          legal  = access && !misal;
        bit          data_k;
        logic [63:0] exp_d;
        logic        exp_wbe;
        logic [4:0]  exp_fwd;

        exp_d   = 64'd0;
        data_k  = 1'b0;
        if (!access) begin
            exp_d = {32'd0, addr}; data_k = 1'b1; exp_wbe = wbe;
        end else if (misal || op == 2'b01) begin
            exp_wbe = 1'b0;
        end else begin
            exp_d = m_load(len, addr, rdata, op == 2'b10); data_k = 1'b1; exp_wbe = wbe;
        end
        exp_fwd = (exp_wbe && !(access && misal)) ? idx : 5'd0;

        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_len = len; in_addr = addr; in_wdata = wdata;
        in_wb_e = wbe; in_wb_idx = idx; out_ready = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1 check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_op = 2'($urandom); in_addr = $urandom; in_wdata = {$urandom, $urandom};
        #1;
        if (legal) begin
            check({tag, ".mem_req"}, 64'(mem_req), 64'd1);
            check({tag, ".mem_addr"}, 64'(mem_addr), 64'(addr & ~32'd7));
            check({tag, ".mem_we"}, 64'(mem_we), 64'(op == 2'b01));
            if (op == 2'b01) begin
                check({tag, ".mem_be"}, 64'(mem_be), m_be(len, addr));
                check({tag, ".mem_wdata"}, mem_wdata, m_wdata(len, wdata));
            end
            for (int g = 0; g < gd; g++) begin
                mem_rvalid = 1'($urandom); out_ready = 1'($urandom);
                @(negedge clk); #1;
                check({tag, ".req_hold"}, 64'(mem_req), 64'd1);
                check({tag, ".addr_hold"}, 64'(mem_addr), 64'(addr & ~32'd7));
                check({tag, ".in_ready_req"}, 64'(in_ready), 64'd0);
            end
            mem_gnt = 1'b1; mem_rvalid = 1'($urandom);
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            #1;
            check({tag, ".req_drop"}, 64'(mem_req), 64'd0);
            check({tag, ".in_ready_wait"}, 64'(in_ready), 64'd0);
            check({tag, ".no_early_out"}, 64'(out_valid), 64'd0);
            for (int r = 0; r < rd; r++) begin
                mem_gnt = 1'($urandom); out_ready = 1'($urandom);
                @(negedge clk);
                mem_gnt = 1'b0;
                #1 check({tag, ".wait_no_out"}, 64'(out_valid), 64'd0);
            end
            mem_rvalid = 1'b1; mem_rdata = rdata;
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
            #1;
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".out_exc"}, 64'(out_exc), 64'(access && misal));
        check({tag, ".out_wb_e"}, 64'(out_wb_e), 64'(exp_wbe));
        check({tag, ".fwd_idx"}, 64'(fwd_idx), 64'(exp_fwd));
        check({tag, ".no_req"}, 64'(mem_req), 64'd0);
        if (data_k) check({tag, ".out_data"}, out_data, exp_d);
        for (int h = 0; h < hd; h++) begin
            out_ready = 1'b0;
            #1 check({tag, ".in_ready_stall"}, 64'(in_ready), 64'd0);
            @(negedge clk); #1;
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_exc"}, 64'(out_exc), 64'(access && misal));
            if (data_k) check({tag, ".hold_data"}, out_data, exp_d);
        end
        out_ready = 1'b1;
        #1 check({tag, ".in_ready_drain"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        #1 check({tag, ".drained"}, 64'(out_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".mem_req"}, 64'(mem_req), 64'd0);
        check({tag, ".mem_we"}, 64'(mem_we), 64'd0);
        check({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, ".mem_be"}, 64'(mem_be), 64'd0);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".out_data"}, out_data, 64'd0);
        check({tag, ".fwd_idx"}, 64'(fwd_idx), 64'd0);
        check({tag, ".fwd_val"}, fwd_val, 64'd0);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Reset asserted in REQ or WAIT, followed by a stray completion.
    task automatic reset_mid(input string tag, input bit in_wait);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b10; in_len = 2'd3; in_addr = 32'h0000_0100;
        in_wb_e = 1'b1; in_wb_idx = 5'd9; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (in_wait) begin
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
        end
        rst = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check({tag, ".late_rvalid"}, 64'(out_valid), 64'd0);
        check({tag, ".late_req"}, 64'(mem_req), 64'd0);
    endtask

    initial begin
        logic [1:0]  op, len;
        logic [31:0] addr;
        int          sz;

        rst = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_len = 2'd0; in_addr = '0;
        in_wdata = '0; in_wb_e = 1'b0; in_wb_idx = 5'd0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b1;
        #12 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        run_op("none", 2'b00, 2'd0, 32'h0000_1234, 64'd0, 1'b1, 5'd5, 64'd0, 0, 0, 0);
        run_op("lb", 2'b10, 2'd0, 32'h0000_1003, 64'd0, 1'b1, 5'd7,
               64'h0000_0000_8000_0000, 0, 0, 0);
        run_op("sh", 2'b01, 2'd1, 32'h0000_2006, 64'h0000_0000_0000_BEEF, 1'b1, 5'd3,
               64'd0, 0, 0, 0);
        run_op("lw_misal", 2'b11, 2'd2, 32'h0000_3002, 64'd0, 1'b1, 5'd4, 64'd0, 0, 0, 0);
        run_op("stall", 2'b11, 2'd2, 32'h0000_4004, 64'd0, 1'b1, 5'd12,
               64'h8765_4321_0FED_CBA9, 4, 1, 3);
        run_op("ld", 2'b10, 2'd3, 32'h0000_5008, 64'd0, 1'b1, 5'd31,
               64'hF123_4567_89AB_CDEF, 1, 2, 0);

        reset_mid("rst_wait", 1'b1);
        reset_mid("rst_req", 1'b0);

        for (int i = 0; i < 60; i++) begin
            op   = 2'($urandom);
            len  = 2'($urandom);
            sz   = 1 << len;
            addr = $urandom;
            if ($urandom_range(3) != 0) addr = addr & ~(32'(sz) - 32'd1);
            run_op($sformatf("rnd%0d", i), op, len, addr, {$urandom, $urandom},
                   1'($urandom), 5'($urandom), {$urandom, $urandom},
                   int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_mem_stage.md
PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DATA_W, default 64, data path width; legal values 32, 64; NB = DATA_W/8 byte lanes.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  upstream (EX) presents an op.
REQ-006 in_ready  out  1  stage accepts the op this cycle.
REQ-007 in_op  in  2  00 none, 01 store, 10 load signed, 11 load unsigned.
REQ-008 in_len  in  2  00 byte, 01 half, 10 word, 11 dword.
REQ-009 in_addr  in  ADDR_W  EX result: address, or pass-through value for op none.
REQ-010 in_wdata  in  DATA_W  store data, right-aligned.
REQ-011 in_wb_e  in  1 / in_wb_idx  in  5  writeback enable / register index.
REQ-012 mem_req  out  1 / mem_we  out  1  memory request / write qualifier.
REQ-013 mem_addr  out  ADDR_W  request address, low log2(NB) bits zero.
REQ-014 mem_be  out  NB / mem_wdata  out  DATA_W  byte enables / lane-placed store data.
REQ-015 mem_gnt  in  1  request accepted this cycle.
REQ-016 mem_rvalid  in  1 / mem_rdata  in  DATA_W  completion (read data or write ack).
REQ-017 out_valid  out  1 / out_ready  in  1  result to WB, downstream accept.
REQ-018 out_data  out  DATA_W / out_wb_e  out  1 / out_wb_idx  out  5 / out_exc  out  1 (misaligned or illegal).
REQ-019 fwd_idx  out  5 / fwd_val  out  DATA_W  bypass to ID.

Function
REQ-020 States SHALL be IDLE, REQ, WAIT; the output register (out_*) SHALL be a separate one-entry holding stage.
REQ-021 in_ready SHALL be 1 iff state==IDLE and (out_valid==0 or out_ready==1); accept = in_valid&&in_ready.
REQ-022 Op none: SHALL produce out_data = zero-extended in_addr, out_valid the cycle after accept, no memory request.
REQ-023 Misaligned access (addr mod size != 0) or dword with DATA_W==32: SHALL set out_exc=1, out_wb_e=0, out_valid next cycle, no memory request.
REQ-024 Legal load/store: IDLE->REQ on accept; mem_req=1, mem_addr=addr with low bits cleared, held stable until mem_gnt.
REQ-025 REQ->WAIT on mem_gnt (mem_req drops next cycle); WAIT->IDLE on mem_rvalid, loading the output register that same edge.
REQ-026 Minimum load/store latency SHALL be 3 cycles: accept T, gnt T+1, rvalid T+2, out_valid T+3.
REQ-027 Store: mem_we=1; mem_be = size-mask shifted left by byte offset; mem_wdata = in_wdata low bytes replicated to every lane.
REQ-028 Load: data = mem_rdata >> (8*offset), truncated to size, sign-extended (op 10) or zero-extended (op 11) to DATA_W.
REQ-029 Store completion SHALL set out_valid with out_wb_e=0; load completion SHALL pass in_wb_e/in_wb_idx captured at accept.
REQ-030 out_* SHALL hold stable while out_valid && !out_ready; out_valid clears on out_ready unless a new result loads the same edge.
REQ-031 mem_rvalid and mem_gnt SHALL be ignored in IDLE; mem_rvalid SHALL be ignored in REQ.
REQ-032 fwd_idx = out_wb_idx when out_valid && out_wb_e && !out_exc, else 0; fwd_val = out_data always.
REQ-033 busy-equivalent: in_ready SHALL be 0 throughout REQ and WAIT regardless of out_ready.

Reset
REQ-034 rst low SHALL immediately force state IDLE and all outputs 0 (in_ready then follows REQ-021 and reads 1).
REQ-035 Reset mid-transaction SHALL drop mem_req at once and discard the op; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-036 Op none, in_addr=0x1234, wb_idx=5, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, fwd_idx=5.
REQ-037 Load signed byte addr=0x1003, DATA_W=64, rdata=0x0000_0000_8000_0000 -> mem_addr=0x1000, out_data=0xFFFF_FFFF_FFFF_FF80 at T+3.
REQ-038 Store half addr=0x2006, wdata=0xBEEF -> mem_we=1, mem_be=0xC0, mem_wdata=0xBEEF replicated; out_wb_e=0.
REQ-039 Load word addr=0x3002 -> no mem_req, out_exc=1, fwd_idx=0.
REQ-040 mem_gnt withheld 4 cycles and out_ready=0 at completion -> mem_addr stable, in_ready=0, out_data held until out_ready.
REQ-041 rst low during WAIT, then rvalid pulse -> all outputs 0, out_valid stays 0.
